// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and width bounds shared by the universal shift register.
package shift_reg_pkg;
    localparam logic [2:0] MODE_CLR  = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SRL  = 3'd2;
    localparam logic [2:0] MODE_SLL  = 3'd3;
    localparam logic [2:0] MODE_SRA  = 3'd4;
    localparam logic [2:0] MODE_SIN  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;
    localparam logic [2:0] MODE_ROL  = 3'd7;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/barrel_shift_n.sv
// barrel_shift_n: combinational logical/arithmetic shift and rotate by a variable distance.
module barrel_shift_n
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SH_W-1:0]  shamt,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);
    logic [SH_W-1:0]          w_rot;
    logic [2*WIDTH-1:0]       w_ror;
    logic [2*WIDTH-1:0]       w_rol;
    logic [WIDTH-1:0]         w_srl;
    logic [WIDTH-1:0]         w_sll;
    logic signed [WIDTH-1:0]  w_sra;
    // rotates wrap the distance; shifts past WIDTH naturally flush to fill
    assign w_rot = SH_W'(32'(shamt) % WIDTH);
    assign w_ror = {data, data} >> w_rot;
    assign w_rol = {data, data} << w_rot;
    assign w_srl = data >> shamt;
    assign w_sll = data << shamt;
    assign w_sra = $signed(data) >>> shamt;
    always_comb
        result = op == MODE_SRL ? w_srl :
                 op == MODE_SLL ? w_sll :
                 op == MODE_SRA ? w_sra :
                 op == MODE_ROR ? w_ror[WIDTH-1:0] :
                 op == MODE_ROL ? w_rol[2*WIDTH-1:WIDTH] : data;
endmodule

// File: rtl/shift_reg_univ_n.sv
// shift_reg_univ_n: universal shift register with parallel load, barrel shifts/rotates
// and LSB-first serial frame assembly with a one-cycle frame-complete strobe.
module shift_reg_univ_n
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] set,
    input  logic [SH_W-1:0]  shamt,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic [SH_W-1:0]  bit_cnt,
    output logic             frame_valid
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-2:0] r_buf;
    logic [SH_W-1:0]  r_cnt;
    logic             r_fv;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_next;
    logic             w_sin;
    logic             w_last;
    barrel_shift_n #(.WIDTH(WIDTH)) u_shift (
        .data   (r_q),
        .shamt  (shamt),
        .op     (mode),
        .result (w_shift)
    );
    assign w_sin  = mode == MODE_SIN;
    assign w_last = r_cnt == SH_W'(WIDTH - 1);
    // the final serial bit goes straight into Q's MSB, so the buffer never holds it
    always_comb
        w_next = mode == MODE_CLR  ? '0 :
                 mode == MODE_LOAD ? set :
                 w_sin             ? (w_last ? {sin, r_buf} : r_q) : w_shift;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q   <= '0;
            r_buf <= '0;
            r_cnt <= '0;
            r_fv  <= 1'b0;
        end else begin
            r_fv <= en && w_sin && w_last;
            if (en) begin
                r_q   <= w_next;
                r_cnt <= w_sin && !w_last ? r_cnt + 1'b1 : '0;
                r_buf <= w_sin && !w_last ? r_buf | ((WIDTH-1)'(sin) << r_cnt) : '0;
            end
        end
    end
    assign Q           = r_q;
    assign sout        = r_q[0];
    assign bit_cnt     = r_cnt;
    assign frame_valid = r_fv;
endmodule

// File: tb/tb_shift_reg_univ_n.sv
// tb_shift_reg_univ_n: directed vectors on 8-bit and 5-bit instances, checked every cycle
// against an arithmetic reference model plus hand-computed literal expectations.
module tb_shift_reg_univ_n;
    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] set8 = 8'h00;
    logic [4:0] set5 = 5'b10011;
    logic [2:0] shamt = 3'd0;
    logic       sin = 1'b0;
    logic [7:0] q8;
    logic [4:0] q5;
    logic [2:0] cnt8, cnt5;
    logic       so8, so5, fv8, fv5;
    int checks = 0;
    int errors = 0;
    int mq[2] = '{0, 0};
    int mb[2] = '{0, 0};
    int mn[2] = '{0, 0};
    int mfv[2] = '{0, 0};
    localparam int WS[2] = '{8, 5};

    shift_reg_univ_n #(.WIDTH(8)) dut8 (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode), .set(set8), .shamt(shamt), .sin(sin),
        .Q(q8), .sout(so8), .bit_cnt(cnt8), .frame_valid(fv8)
    );
    shift_reg_univ_n #(.WIDTH(5)) dut5 (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode), .set(set5), .shamt(shamt), .sin(sin),
        .Q(q5), .sout(so5), .bit_cnt(cnt5), .frame_valid(fv5)
    );

    always #5 clk = ~clk;

    function automatic int f_next(int w, int m, int q, int sv, int s);
        int mask = (1 << w) - 1;
        int r = s % w;
        case (m)
            0: return 0;
            1: return sv & mask;
            2: return q / (1 << s);
            3: return (q * (1 << s)) & mask;
            4: return q / (1 << s) + (q >= (1 << (w - 1)) ? mask - (mask / (1 << s)) : 0);
            6: return ((q >> r) | (q << (w - r))) & mask;
            7: return ((q << r) | (q >> (w - r))) & mask;
            default: return q;
        endcase
    endfunction

    always @(posedge clk or negedge clrn) begin
        for (int k = 0; k < 2; k++) begin
            if (!clrn) begin
                mq[k] <= 0; mb[k] <= 0; mn[k] <= 0; mfv[k] <= 0;
            end else begin
                mfv[k] <= 0;
                if (en && mode == 3'd5 && mn[k] == WS[k] - 1) begin
                    mq[k] <= mb[k] + (int'(sin) << (WS[k] - 1));
                    mb[k] <= 0; mn[k] <= 0; mfv[k] <= 1;
                end else if (en && mode == 3'd5) begin
                    mb[k] <= mb[k] + (int'(sin) << mn[k]);
                    mn[k] <= mn[k] + 1;
                end else if (en) begin
                    mq[k] <= f_next(WS[k], int'(mode), mq[k], k == 0 ? int'(set8) : int'(set5), int'(shamt));
                    mb[k] <= 0; mn[k] <= 0;
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("q8", int'(q8), mq[0]);
        chk("cnt8", int'(cnt8), mn[0]);
        chk("fv8", int'(fv8), mfv[0]);
        chk("sout8", int'(so8), mq[0] & 1);
        chk("q5", int'(q5), mq[1]);
        chk("cnt5", int'(cnt5), mn[1]);
        chk("fv5", int'(fv5), mfv[1]);
        chk("sout5", int'(so5), mq[1] & 1);
    end

    task automatic op(logic [2:0] m, logic [2:0] s, logic [7:0] sv, logic si);
        @(negedge clk);
        en = 1'b1; mode = m; shamt = s; set8 = sv; sin = si;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; mode = 3'd2; shamt = 3'd1;
        @(posedge clk); #1;
    endtask

    logic [7:0] bits_a5 = 8'hA5;
    logic [7:0] bits_5c = 8'h5C;
    logic [2:0] t_m [9] = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd4, 3'd6, 3'd7, 3'd7, 3'd6};
    logic [2:0] t_s [9] = '{3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd1, 3'd7, 3'd1};
    logic [7:0] t_e [9] = '{8'h16, 8'h68, 8'hED, 8'hB4, 8'hB4, 8'h96, 8'h69, 8'h5A, 8'h5A};

    initial begin
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        // async reset with no clock edge
        op(3'd1, 3'd0, 8'hB4, 1'b0);
        chk("load_b4", int'(q8), 8'hB4);
        op(3'd5, 3'd0, 8'h00, 1'b1);
        op(3'd5, 3'd0, 8'h00, 1'b1);
        chk("cnt_before_rst", int'(cnt8), 2);
        #2 clrn = 1'b0;
        #1;
        chk("rst_q", int'(q8), 0);
        chk("rst_cnt", int'(cnt8), 0);
        chk("rst_fv", int'(fv8), 0);
        @(negedge clk); clrn = 1'b1;
        // shifts and rotates from B4
        for (int i = 0; i < 9; i++) begin
            op(3'd1, 3'd0, 8'hB4, 1'b0);
            op(t_m[i], t_s[i], 8'hB4, 1'b0);
            chk("shift8", int'(q8), int'(t_e[i]));
        end
        // non-power-of-2 width, shamt beyond WIDTH
        op(3'd1, 3'd0, 8'h00, 1'b0);
        op(3'd2, 3'd6, 8'h00, 1'b0);
        chk("srl5_6", int'(q5), 0);
        op(3'd1, 3'd0, 8'h00, 1'b0);
        op(3'd4, 3'd7, 8'h00, 1'b0);
        chk("sra5_7", int'(q5), 5'b11111);
        op(3'd1, 3'd0, 8'h00, 1'b0);
        op(3'd6, 3'd6, 8'h00, 1'b0);
        chk("ror5_6", int'(q5), 5'b11001);
        // serial frame A5 then back-to-back FF
        op(3'd1, 3'd0, 8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            op(3'd5, 3'd0, 8'h00, bits_a5[i]);
            chk("sin_q", int'(q8), i < 7 ? 8'h3C : 8'hA5);
            chk("sin_fv", int'(fv8), i == 7 ? 1 : 0);
        end
        chk("sin_cnt", int'(cnt8), 0);
        for (int i = 0; i < 8; i++) begin
            op(3'd5, 3'd0, 8'h00, 1'b1);
            chk("sin2_fv", int'(fv8), i == 7 ? 1 : 0);
        end
        chk("sin2_q", int'(q8), 8'hFF);
        // pause then abort
        for (int i = 0; i < 3; i++) op(3'd5, 3'd0, 8'h00, 1'b1);
        idle();
        idle();
        chk("pause_cnt", int'(cnt8), 3);
        chk("pause_q", int'(q8), 8'hFF);
        op(3'd5, 3'd0, 8'h00, 1'b0);
        op(3'd5, 3'd0, 8'h00, 1'b1);
        chk("resume_cnt", int'(cnt8), 5);
        op(3'd1, 3'd0, 8'h11, 1'b0);
        chk("abort_cnt", int'(cnt8), 0);
        chk("abort_q", int'(q8), 8'h11);
        chk("abort_fv", int'(fv8), 0);
        for (int i = 0; i < 8; i++) op(3'd5, 3'd0, 8'h00, bits_5c[i]);
        chk("fresh_q", int'(q8), 8'h5C);
        chk("fresh_fv", int'(fv8), 1);
        // sweep every mode and distance against the model
        for (int m = 0; m < 8; m++) begin
            for (int s = 0; s < 8; s++) begin
                op(3'd1, 3'd0, 8'h96 ^ 8'(s * 37), 1'b0);
                op(3'(m), 3'(s), 8'h4D, 1'(s));
                if (s == 4) idle();
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_reg_univ_n.md
Name: shift_reg_univ_n

Overview:
Parametrised universal shift register. WIDTH-bit data path with parallel load, variable-distance logical, arithmetic and rotate shifts, and serial-in frame assembly. Adds an enable, async reset and a frame-complete strobe. Serves as the general-purpose shifter/deserialiser for later lab datapaths (serial receivers, LFSR front-ends, display scrollers).

Parameters:
WIDTH, 8, data width in bits; legal range 2..32.
SH_W, $clog2(WIDTH) (localparam), width of shamt and bit_cnt.

Ports:
clk  input  1  rising-edge clock
clrn  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state
mode  input  3  operation select, see Behaviour
set  input  WIDTH  parallel load value
shamt  input  SH_W  shift/rotate distance
sin  input  1  serial data in (mode SIN)
Q  output  WIDTH  register contents
sout  output  1  serial out = Q[0] (combinational from Q)
bit_cnt  output  SH_W  bits collected in current serial frame
frame_valid  output  1  one-cycle strobe: Q holds a newly assembled frame

Behaviour:
- Reset is async, active-low: clrn=0 forces Q=0, bit_cnt=0, assembly buffer=0, frame_valid=0 immediately, regardless of clk/en. Released state is idle.
- All updates on posedge clk when en=1. en=0: Q, bit_cnt, buffer hold; frame_valid=0.
- Modes (en=1), one-cycle latency, result visible the cycle after the edge:
  0 CLR: Q<=0.
  1 LOAD: Q<=set.
  2 SRL: Q<=Q>>shamt, zero fill.
  3 SLL: Q<=Q<<shamt, zero fill.
  4 SRA: Q<=Q>>>shamt, fill with Q[WIDTH-1].
  5 SIN: serial assembly (below); Q unchanged until frame completes.
  6 ROR: rotate right by shamt.
  7 ROL: rotate left by shamt.
- shamt=0: Q unchanged in modes 2,3,4,6,7. shamt>=WIDTH (non-power-of-2 WIDTH only): SRL/SLL give 0, SRA gives all-sign, ROR/ROL use shamt mod WIDTH.
- SIN: buffer[bit_cnt]<=sin (LSB first); bit_cnt<=bit_cnt+1. When bit_cnt==WIDTH-1 at the edge: Q<=buffer with bit WIDTH-1 = current sin (current bit is included), bit_cnt<=0, buffer<=0, frame_valid<=1 for exactly one cycle. Back-to-back frames allowed with no gap.
- Any mode other than SIN with en=1 aborts a partial frame: bit_cnt<=0, buffer<=0. en=0 during SIN pauses the frame without loss.
- frame_valid is registered; high only in the cycle following the completing edge.
- Reset mid-frame discards partial data; next frame starts at bit 0.
- No X propagation: all registers have defined reset values; illegal states unreachable.

Decomposition:
- Shared package shift_reg_pkg: mode constants MODE_CLR..MODE_ROL (3-bit), WIDTH bounds.
- One combinational sub-module barrel_shift_n (WIDTH parameter; inputs data, shamt, op[2:0]; output result) implementing SRL/SLL/SRA/ROR/ROL. Top holds registers, serial assembly counter and strobe.

Test Plan:
- Reset: load 8'hB4, drive clrn=0 between edges -> Q=8'h00, bit_cnt=0, frame_valid=0 without a clock edge.
- Shifts from Q=8'hB4: SRL shamt=3 -> 8'h16; SLL shamt=1 -> 8'h68; SRA shamt=2 -> 8'hED; shamt=0 in any shift mode -> 8'hB4 unchanged.
- Rotates from Q=8'hB4: ROR shamt=3 -> 8'h96; ROL shamt=1 -> 8'h69; ROL shamt=7 equals ROR shamt=1 -> 8'h5A.
- Serial frame: LOAD 8'h3C, then SIN with sin=1,0,1,0,0,1,0,1 over 8 edges -> Q stays 8'h3C for 7 cycles, then Q=8'hA5, frame_valid high exactly one cycle, bit_cnt=0; immediately follow with 8 more bits (all 1) -> Q=8'hFF, second strobe.
- Abort/pause: SIN 3 bits, en=0 for 2 cycles (bit_cnt stays 3), resume 2 bits, then LOAD 8'h11 -> bit_cnt=0, Q=8'h11, no strobe; a fresh 8-bit SIN frame then assembles correctly from bit 0.
- WIDTH=5 instance: LOAD 5'b10011, SRL shamt=6 -> 0; SRA shamt=7 -> 5'b11111; ROR shamt=6 -> 5'b11001.
